shift_issue_stage: RTL
======================

Name: shift_issue_stage

Overview:
Execute-stage issue buffer that sits directly upstream of the barrel shifter. It accepts decoded-stage RV32I instructions with register operands and validates the shift subset (SLL/SRL/SRA/SLLI/SRLI/SRAI). It produces the shifter operand A, shift amount and shift select, then holds them in a small FIFO with a valid/ready handshake. Pipeline stalls and flushes are absorbed here so the combinational shifter always sees a stable, legal operand set.

Parameters:
DEPTH, 2, buffer entries; power of two, >= 2
CNT_W, 8, width of the saturating illegal-instruction counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream presents an instruction
in_ready  output  1  buffer can accept this cycle
instr  input  32  full RV32I instruction word
rs1_data  input  32  forwarded rs1 value
rs2_data  input  32  forwarded rs2 value (R-type shamt source)
flush  input  1  synchronous pipeline flush
out_valid  output  1  head entry valid toward shifter
out_ready  input  1  downstream consumes head this cycle
A  output  32  shifter operand (rs1 value)
shamt  output  5  shift amount
shiftSel  output  2  00 SLL, 01 SRL, 10 SRA, 11 no-op
rd_out  output  5  destination register, instr[11:7]
out_illegal  output  1  head entry is not a legal shift
illegal_cnt  output  CNT_W  saturating count of accepted illegal entries

Behaviour:
- Reset (async, no clock needed): count=0, pointers=0, all storage zeroed. Outputs immediately read out_valid=0, in_ready=1, A=0, shamt=0, shiftSel=00, rd_out=0, out_illegal=0, illegal_cnt=0.
- Decode is combinational on the input and is stored at accept. Storage holds A, shamt, shiftSel, rd and illegal.
  - opcode 0010011 (I): shamt=instr[24:20].
  - opcode 0110011 (R): shamt=rs2_data[4:0].
  - funct3=001 with funct7=0000000 -> SLL.
  - funct3=101 with funct7=0000000 -> SRL.
  - funct3=101 with funct7=0100000 -> SRA.
  - Anything else is illegal: shiftSel=11, shamt=0, A=rs1_data, illegal=1.
- Accept on the clk edge where in_valid && in_ready. Pop on the edge where out_valid && out_ready.
- in_ready = (count != DEPTH), derived from registered count with no combinational path from out_ready. When full, a same-cycle pop does not admit a push. in_ready rises the cycle after the pop.
- out_valid = (count != 0). Outputs come from the head entry. Latency from accept to out_valid is 1 cycle.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Order is strictly FIFO.
- Outputs stay stable while out_valid && !out_ready.
- flush has priority over push and pop. The next edge sets count=0 and pointers=0, and discards any same-cycle accept.
- illegal_cnt increments on accept of an illegal entry, including one discarded by a same-cycle flush. It saturates at 2^CNT_W-1 and clears only on rst.
- rst asserted mid-operation discards all entries immediately.

Decomposition:
- Package shift_pkg holds:
  - opcode constants OP_IMM=0010011 and OP_REG=0110011
  - funct3 constants F3_SLL=001 and F3_SR=101
  - funct7 constants F7_LOG=0000000 and F7_ARITH=0100000
  - shift select constants SEL_SLL=00, SEL_SRL=01, SEL_SRA=10, SEL_NOP=11
  - the entry-record layout
- One combinational sub-module, shift_decode (instr, rs1_data, rs2_data -> A, shamt, shiftSel, rd, illegal). The FIFO and counter stay in shift_issue_stage.

Test Plan:
- SLLI: instr=0x00309293, rs1_data=0x000000F0, out_ready=1 -> next cycle out_valid=1, A=0x000000F0, shamt=3, shiftSel=00, rd_out=5, out_illegal=0.
- SRA: instr=0x403153B3, rs1_data=0x80000000, rs2_data=0xFFFFFF24 -> shamt=4, shiftSel=10, rd_out=7, A=0x80000000.
- Backpressure with DEPTH=2, out_ready=0, three consecutive pushes:
  - in_ready=0 after the second accept; the third is held upstream.
  - Raise out_ready: entries emerge in order, and in_ready=1 the cycle after the first pop.
- Illegal: instr=0x0230D293 (funct7=0000001) -> out_illegal=1, shiftSel=11, shamt=0, illegal_cnt=1. With CNT_W=2, 5 illegal accepts -> illegal_cnt=3.
- Flush: 2 entries held, in_valid=1 and flush=1 in the same cycle -> next cycle out_valid=0, in_ready=1, and the pushed instruction never appears.
- Async reset: assert rst between clock edges with 1 entry valid -> out_valid=0 and A=0 immediately, before the next edge.

Source files
------------

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared constants and the issue-buffer entry record for the
//                shift issue stage (RV32I shift subset decode).
//  Contents    : opcode / funct3 / funct7 encodings, shifter select codes,
//                entry_t record stored in the issue FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    // RV32I major opcodes carrying shifts
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    // funct3: left shift, right shifts (logical/arithmetic share 101)
    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_SR    = 3'b101;

    // funct7: logical vs arithmetic
    localparam logic [6:0] F7_LOG   = 7'b0000000;
    localparam logic [6:0] F7_ARITH = 7'b0100000;

    // Shifter select codes
    localparam logic [1:0] SEL_SLL  = 2'b00;
    localparam logic [1:0] SEL_SRL  = 2'b01;
    localparam logic [1:0] SEL_SRA  = 2'b10;
    localparam logic [1:0] SEL_NOP  = 2'b11;

    // One issue-buffer entry
    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  shamt;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        illegal;
    } entry_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_issue_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_issue_stage_if
//  Description : Upstream/downstream handshake bundle of the shift issue
//                stage.
//  Ports       : master - upstream + downstream environment (drives inputs)
//                slave  - the issue stage itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface shift_issue_stage_if #(
    parameter int CNT_W = 8
);
    // upstream side
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [31:0]      rs1_data;
    logic [31:0]      rs2_data;
    logic             flush;
    // shifter side
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      A;
    logic [4:0]       shamt;
    logic [1:0]       shiftSel;
    logic [4:0]       rd_out;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output in_valid, instr, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, out_valid, A, shamt, shiftSel, rd_out,
               out_illegal, illegal_cnt
    );

    modport slave (
        input  in_valid, instr, rs1_data, rs2_data, flush, out_ready,
        output in_ready, out_valid, A, shamt, shiftSel, rd_out,
               out_illegal, illegal_cnt
    );
endinterface : shift_issue_stage_if
`default_nettype wire

// File: rtl/shift_decode.sv
`default_nettype none
// ============================================================================
//  Module      : shift_decode
//  Description : Combinational decode of the RV32I shift subset
//                (SLL/SRL/SRA/SLLI/SRLI/SRAI) into shifter operands.
//  Ports       : instr, rs1_data, rs2_data -> A, shamt, shiftSel, rd, illegal
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_decode
    import shift_pkg::*;
(
    input  wire logic [31:0] instr,
    input  wire logic [31:0] rs1_data,
    input  wire logic [31:0] rs2_data,
    output logic      [31:0] A,
    output logic      [4:0]  shamt,
    output logic      [1:0]  shiftSel,
    output logic      [4:0]  rd,
    output logic             illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [4:0] w_amt;
    logic       w_shift_op;

    assign w_opcode   = instr[6:0];
    assign w_f3       = instr[14:12];
    assign w_f7       = instr[31:25];
    assign w_shift_op = (w_opcode == OP_IMM) || (w_opcode == OP_REG);
    // I-type carries the amount in the rs2 field; R-type takes it from rs2 data
    assign w_amt      = (w_opcode == OP_IMM) ? instr[24:20] : rs2_data[4:0];

    // rs1 index and upper rs2 bits are never needed by the shifter
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, instr[19:15], rs2_data[31:5]};

    always_comb begin
        A        = rs1_data;
        rd       = instr[11:7];
        shamt    = 5'd0;
        shiftSel = SEL_NOP;
        illegal  = 1'b1;
        if (w_shift_op) begin
            if (w_f3 == F3_SLL && w_f7 == F7_LOG) begin
                shiftSel = SEL_SLL;
                shamt    = w_amt;
                illegal  = 1'b0;
            end else if (w_f3 == F3_SR && w_f7 == F7_LOG) begin
                shiftSel = SEL_SRL;
                shamt    = w_amt;
                illegal  = 1'b0;
            end else if (w_f3 == F3_SR && w_f7 == F7_ARITH) begin
                shiftSel = SEL_SRA;
                shamt    = w_amt;
                illegal  = 1'b0;
            end
        end
    end

endmodule : shift_decode
`default_nettype wire

// File: rtl/shift_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : shift_issue_stage
//  Description : Issue buffer ahead of the barrel shifter. Decodes shift
//                instructions at accept and queues them in a DEPTH-entry FIFO
//                with valid/ready handshakes, flush, and a saturating count of
//                accepted illegal instructions.
//  Ports       : clk, rst (async, active high)
//                bus - shift_issue_stage_if.slave (handshake + operands)
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_issue_stage
    import shift_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    shift_issue_stage_if.slave bus
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0]   C_FULL    = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [CNT_W-1:0] r_ill_cnt;

    entry_t w_dec;
    entry_t w_head;
    logic   w_push;
    logic   w_pop;

    shift_decode u_decode (
        .instr    (bus.instr),
        .rs1_data (bus.rs1_data),
        .rs2_data (bus.rs2_data),
        .A        (w_dec.a),
        .shamt    (w_dec.shamt),
        .shiftSel (w_dec.sel),
        .rd       (w_dec.rd),
        .illegal  (w_dec.illegal)
    );

    // in_ready comes only from the registered count, so a pop while full
    // cannot admit a push in the same cycle.
    assign bus.in_ready  = (r_count != C_FULL);
    assign bus.out_valid = (r_count != '0);
    assign w_push        = bus.in_valid && bus.in_ready;
    assign w_pop         = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ill_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // An illegal accept is counted even when a flush discards it
            if (w_push && w_dec.illegal && (r_ill_cnt != C_CNT_MAX)) begin
                r_ill_cnt <= r_ill_cnt + 1'b1;
            end
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= w_dec;
                    r_wr_ptr        <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    assign w_head          = r_mem[r_rd_ptr];
    assign bus.A           = w_head.a;
    assign bus.shamt       = w_head.shamt;
    assign bus.shiftSel    = w_head.sel;
    assign bus.rd_out      = w_head.rd;
    assign bus.out_illegal = w_head.illegal;
    assign bus.illegal_cnt = r_ill_cnt;

endmodule : shift_issue_stage
`default_nettype wire
